// File: rtl/fft_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl_if
// Brief    : Streaming handshakes and FFT-core frame bus for fft_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINT    = 16
);
    logic                          s_valid;
    logic                          s_ready;
    logic [DATA_WIDTH-1:0]         s_data;
    logic                          m_valid;
    logic                          m_ready;
    logic [DATA_WIDTH-1:0]         m_data;
    logic                          m_last;
    logic [N_POINT*DATA_WIDTH-1:0] core_x;
    logic [N_POINT*DATA_WIDTH-1:0] core_y;

    // slave: the frame controller itself
    modport slave (
        input  s_valid, s_data, m_ready, core_y,
        output s_ready, m_valid, m_data, m_last, core_x
    );

    // master: the sample source, sink and FFT core around the controller
    modport master (
        output s_valid, s_data, m_ready, core_y,
        input  s_ready, m_valid, m_data, m_last, core_x
    );
endinterface
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl
// Brief    : Collects a frame of samples for a fixed-latency FFT core and
//            streams the core result back out with last-sample marking.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int N_POINT      = 16,
    parameter int CORE_LATENCY = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        flush,
    fft_frame_ctrl_if.slave  bus,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int c_IDX_W = $clog2(N_POINT);
    localparam int c_LAT_W = $clog2(CORE_LATENCY + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_POINT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_LAT_W-1:0] c_LAT_MAX  = c_LAT_W'(CORE_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                        r_state;
    logic [c_IDX_W-1:0]            r_wr_idx;
    logic [c_IDX_W-1:0]            r_rd_idx;
    logic [c_LAT_W-1:0]            r_lat_cnt;
    logic                          r_s_ready;
    logic                          r_m_valid;
    logic [15:0]                   r_frame_cnt;

    logic                          w_accept;
    logic                          w_consume;
    logic                          w_capture;
    logic                          w_wr_en;
    logic                          w_cap_en;
    logic [N_POINT*DATA_WIDTH-1:0] w_out_flat;

    assign w_accept  = bus.s_valid && r_s_ready && (r_state == ST_FILL);
    assign w_consume = r_m_valid && bus.m_ready && (r_state == ST_DRAIN);
    assign w_capture = (r_state == ST_WAIT) && (r_lat_cnt == c_LAT_MAX);

    // A flush on the same edge discards the coinciding accept or capture.
    assign w_wr_en  = w_accept  && !flush;
    assign w_cap_en = w_capture && !flush;

    // Per-slot buffers: an input slot only moves on its own accept, which
    // keeps core_x frozen for the whole core latency window.
    genvar k;
    generate
        for (k = 0; k < N_POINT; k++) begin : g_slot
            logic [DATA_WIDTH-1:0] r_in;
            logic [DATA_WIDTH-1:0] r_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_in  <= '0;
                    r_out <= '0;
                end else begin
                    if (w_wr_en && (r_wr_idx == c_IDX_W'(k))) begin
                        r_in <= bus.s_data;
                    end
                    if (w_cap_en) begin
                        r_out <= bus.core_y[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign bus.core_x[k*DATA_WIDTH +: DATA_WIDTH] = r_in;
            assign w_out_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_out;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_lat_cnt   <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (flush) begin
            r_state   <= ST_FILL;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_lat_cnt <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_wr_idx <= r_wr_idx + c_IDX_ONE;
                        if (r_wr_idx == c_IDX_LAST) begin
                            r_state   <= ST_WAIT;
                            r_lat_cnt <= '0;
                            r_s_ready <= 1'b0;
                        end
                    end
                end

                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
                    if (w_capture) begin
                        r_state   <= ST_DRAIN;
                        r_rd_idx  <= '0;
                        r_m_valid <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (w_consume) begin
                        r_rd_idx <= r_rd_idx + c_IDX_ONE;
                        if (r_rd_idx == c_IDX_LAST) begin
                            r_state     <= ST_FILL;
                            r_m_valid   <= 1'b0;
                            r_s_ready   <= 1'b1;
                            r_wr_idx    <= '0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_FILL;
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b1;
                end
            endcase
        end
    end

    // m_data and m_last derive only from rd_idx and the output buffer, so
    // they hold by construction while the sink stalls.
    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = w_out_flat[r_rd_idx*DATA_WIDTH +: DATA_WIDTH];
    assign bus.m_last  = (r_state == ST_DRAIN) && (r_rd_idx == c_IDX_LAST);
    assign busy        = (r_state != ST_FILL) || (r_wr_idx != '0);
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_ctrl
// Brief    : Directed self-checking bench for fft_frame_ctrl with a
//            four-edge delay-line FFT core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int DW  = 16;
    localparam int NP  = 16;
    localparam int LAT = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    fft_frame_ctrl_if #(.DATA_WIDTH(DW), .N_POINT(NP)) bus ();

    fft_frame_ctrl #(
        .DATA_WIDTH  (DW),
        .N_POINT     (NP),
        .CORE_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus.slave),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Core model: core_y is core_x delayed by four rising edges.
    logic [NP*DW-1:0] p1 = '0;
    logic [NP*DW-1:0] p2 = '0;
    logic [NP*DW-1:0] p3 = '0;
    initial bus.core_y = '0;
    always @(posedge clk) begin
        p1         <= bus.core_x;
        p2         <= p1;
        p3         <= p2;
        bus.core_y <= p3;
    end

    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] exp_x [NP];
    logic [DW-1:0] exp_y [NP];
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_core(input string tag);
        for (int k = 0; k < NP; k++) begin
            check(tag, 32'(bus.core_x[k*DW +: DW]), 32'(exp_x[k]));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 0);
        check({tag, "_m_last"},  32'(bus.m_last), 0);
        check({tag, "_m_data"},  32'(bus.m_data), 0);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_fcnt"},    32'(frame_cnt), 0);
        for (int k = 0; k < NP; k++) exp_x[k] = '0;
        check_core({tag, "_core_x"});
    endtask

    // Called and returning at a falling edge; inputs set here act on the next rising edge.
    task automatic send_frame(input logic [DW-1:0] base, input bit gaps);
        int n     = 0;
        int guard = 0;
        bit v;
        bit acc;
        bus.m_ready = 1'b1;
        while (n < NP && guard < 200) begin
            guard++;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid = v;
            bus.s_data  = v ? (base + DW'(n)) : 16'hDEAD;
            acc = v && bus.s_ready;
            if (acc) begin
                exp_x[n] = bus.s_data;
                n++;
            end
            @(negedge clk);
            check_core("core_x_slot");
            check("busy_fill", 32'(busy), 32'(n != 0));
            check("s_ready_fill", 32'(bus.s_ready), 32'(n < NP));
            check("m_valid_fill", 32'(bus.m_valid), 0);
        end
        bus.s_valid = 1'b0;
        check("accepts", n, NP);
    endtask

    task automatic receive_frame(input bit alt, input int stop, input bit chain,
                                 input logic [DW-1:0] next_base);
        int cyc     = 0;
        int idx     = 0;
        int guard   = 0;
        bit ph      = 1'b1;
        bit r;
        bit stalled = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        for (int k = 0; k < NP; k++) exp_y[k] = exp_x[k];
        while (!bus.m_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, LAT + 1);
        check("m_valid_up", 32'(bus.m_valid), 1);
        while (idx < stop && guard < 100) begin
            guard++;
            check("m_valid_drain", 32'(bus.m_valid), 1);
            check("s_ready_drain", 32'(bus.s_ready), 0);
            check("m_data", 32'(bus.m_data), 32'(exp_y[idx]));
            check("m_last", 32'(bus.m_last), 32'(idx == NP - 1));
            if (stalled) begin
                check("hold_data", 32'(bus.m_data), 32'(held_d));
                check("hold_last", 32'(bus.m_last), 32'(held_l));
            end
            r  = alt ? ph : 1'b1;
            ph = ~ph;
            bus.m_ready = r;
            held_d  = bus.m_data;
            held_l  = bus.m_last;
            stalled = !r;
            if (r) begin
                idx++;
                if (chain && idx == NP) begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = next_base;
                end
            end
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        check("consumes", idx, stop);
        if (stop == NP) begin
            exp_cnt++;
            check("m_valid_done", 32'(bus.m_valid), 0);
            check("m_last_done", 32'(bus.m_last), 0);
            check("s_ready_done", 32'(bus.s_ready), 1);
            check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state and release
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_release", 32'(bus.s_ready), 1);

        // Ramp frame, sink always ready
        send_frame(16'h0000, 1'b0);
        receive_frame(1'b0, NP, 1'b0, '0);

        // Gapped input, alternating sink stalls
        send_frame(16'h0100, 1'b1);
        receive_frame(1'b1, NP, 1'b0, '0);

        // Flush after seven consumes, with a coinciding consume request
        send_frame(16'h0200, 1'b0);
        receive_frame(1'b0, 7, 1'b0, '0);
        flush       = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        check("flush_m_valid", 32'(bus.m_valid), 0);
        check("flush_s_ready", 32'(bus.s_ready), 1);
        check("flush_busy", 32'(busy), 0);
        check("flush_fcnt", 32'(frame_cnt), 32'(exp_cnt));
        check_core("flush_core_x");
        send_frame(16'h0300, 1'b0);
        receive_frame(1'b0, NP, 1'b0, '0);

        // Asynchronous reset while waiting on the core
        send_frame(16'h0500, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_wait");
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_rerelease", 32'(bus.s_ready), 1);
        check("fcnt_rerelease", 32'(frame_cnt), 0);

        // Back-to-back frames with s_valid raised during the final consume
        send_frame(16'h0600, 1'b0);
        receive_frame(1'b0, NP, 1'b1, 16'h0700);
        send_frame(16'h0700, 1'b0);
        receive_frame(1'b0, NP, 1'b0, '0);
        check("fcnt_two", 32'(frame_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one sample word.
REQ-002 Parameter N_POINT, default 16: samples per frame; power of two, at least 2.
REQ-003 Parameter CORE_LATENCY, default 4: clock edges from a stable core_x to a valid core_y; at least 1.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 flush  in  1: synchronous abort of the current frame.
REQ-007 s_valid  in  1: input sample valid.
REQ-008 s_ready  out  1: controller accepts an input sample.
REQ-009 s_data  in  DATA_WIDTH: input sample.
REQ-010 core_x  out  N_POINT*DATA_WIDTH: frame to the FFT core; sample k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 core_y  in  N_POINT*DATA_WIDTH: FFT core result, same packing as core_x.
REQ-012 m_valid  out  1: output sample valid.
REQ-013 m_ready  in  1: downstream accepts an output sample.
REQ-014 m_data  out  DATA_WIDTH: output sample.
REQ-015 m_last  out  1: marks the final sample of a frame.
REQ-016 busy  out  1: a frame is in progress.
REQ-017 frame_cnt  out  16: count of fully drained frames; wraps modulo 2^16.

Function
REQ-018 The state machine SHALL have three states (FILL, WAIT, DRAIN) plus two counters: wr_idx/rd_idx of width $clog2(N_POINT), and lat_cnt of width $clog2(CORE_LATENCY+1).
REQ-019 An accept SHALL occur on s_valid && s_ready; a sample SHALL be consumed on m_valid && m_ready.
REQ-020 s_ready SHALL be registered and high only while in FILL.
REQ-021 In FILL, each accept SHALL write s_data into input buffer slot wr_idx, then increment wr_idx.
REQ-022 On the accept at wr_idx == N_POINT-1, the block SHALL enter WAIT, clear lat_cnt, and clear s_ready on that same edge.
REQ-023 core_x SHALL be driven directly from the input buffer registers; a slot SHALL change only on its own accept, so core_x is held stable throughout WAIT.
REQ-024 In WAIT, lat_cnt SHALL increment on every edge.
REQ-025 On the WAIT edge where lat_cnt == CORE_LATENCY, the block SHALL capture all of core_y into the output buffer, clear rd_idx, set m_valid, and enter DRAIN.
REQ-026 The first m_valid SHALL therefore appear CORE_LATENCY+1 cycles after the last input accept.
REQ-027 In DRAIN, m_data SHALL equal output buffer slot rd_idx.
REQ-028 In DRAIN, m_last SHALL be high exactly when rd_idx == N_POINT-1.
REQ-029 During a stall (m_valid && !m_ready), m_data and m_last SHALL be held stable.
REQ-030 Each consume SHALL increment rd_idx.
REQ-031 The consume with m_last high SHALL, on that edge: clear m_valid, increment frame_cnt (wrapping), set s_ready, clear wr_idx, and enter FILL.
REQ-032 There SHALL be no dead cycle between frames; a new frame is accepted the cycle after the last output consume.
REQ-033 busy SHALL equal (state != FILL) || (wr_idx != 0).
REQ-034 m_valid SHALL never be high outside DRAIN; s_ready and m_valid SHALL never be high in the same cycle.
REQ-035 flush SHALL take priority over all other events. On the flush edge the block SHALL: enter FILL, clear wr_idx, rd_idx and lat_cnt, clear m_valid, and set s_ready.
REQ-036 flush SHALL leave both buffers and frame_cnt unchanged.
REQ-037 An accept or consume that coincides with flush SHALL be discarded.
REQ-038 Handshake inputs arriving in states where the matching valid/ready is low SHALL be ignored.

Reset
REQ-039 While rst_n is low, the block SHALL force: state FILL, all counters 0, s_ready 0, m_valid 0, m_last 0, busy 0, frame_cnt 0, m_data 0, and all buffer contents (hence core_x) 0.
REQ-040 On the first rising edge after rst_n deasserts, s_ready SHALL become 1.
REQ-041 Assertion of rst_n mid-frame in any state SHALL abort the frame with no partial output.

Verification
(Bench uses N_POINT=16, CORE_LATENCY=4, and a core model that delays core_x by 4 edges onto core_y.)
REQ-042 Reset release, then ramp 0..15 back-to-back with m_ready=1 -> s_ready low the cycle after the 16th accept; m_valid high 5 cycles after the last accept; 16 outputs match the model in order; m_last only on the 16th; frame_cnt=1.
REQ-043 m_ready pattern 1,0,1,0... during DRAIN -> m_data and m_last stable across every stall; no duplicated or dropped samples; exactly 16 consumes.
REQ-044 s_valid with random gaps (about 50%) -> each core_x slot changes only on its own accept; WAIT is entered only after the 16th accept.
REQ-045 flush after 7 output consumes -> m_valid 0 and s_ready 1 on the next cycle; frame_cnt unchanged; a following 16-sample frame completes correctly.
REQ-046 rst_n pulled low during WAIT -> outputs reach their reset values immediately, without a clock; after release, s_ready rises on the first edge; frame_cnt=0.
REQ-047 Two frames back-to-back, with a new s_valid asserted during the last consume -> the first new accept occurs the cycle after m_last; frame_cnt=2.
